// File: rtl/mem_access_unit.sv
// Byte-addressed CPU to word-wide RAM bridge: sub-word stores become read-modify-write,
// doublewords become two word accesses, and misaligned requests get an error response.
module mem_access_unit #(
    parameter int ADDR_BITS = 19
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic [0:ADDR_BITS-1]   req_addr,
    input  logic [0:63]            req_wdata,
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [0:63]            resp_rdata,
    output logic [0:ADDR_BITS-3]   mem_addr,
    output logic                   mem_we,
    output logic [0:31]            mem_wdata,
    input  logic [0:31]            mem_rdata
);

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [2:0] {IDLE, RD1, RD2, RMW, WR1, WR2, RESP} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic [0:63] wdata_q;
    logic [0:31] first_word;
    logic        we_q;

    logic [1:0]  req_offset;
    logic        misaligned;
    logic [0:7]  sel_byte;
    logic [0:15] sel_half;
    logic [0:31] load_word;
    logic [0:31] merged_word;

    // Byte offset 0 is the most significant lane (big-endian), so lane k starts at bit 8*k.
    always_comb begin
        req_offset  = {req_addr[ADDR_BITS-2], req_addr[ADDR_BITS-1]};
        misaligned  = 1'b0;
        case (req_size)
            SZ_HALF:  misaligned = req_offset[0];
            SZ_WORD:  misaligned = |req_offset;
            SZ_DWORD: misaligned = (|req_offset) | req_addr[ADDR_BITS-3];
            default:  misaligned = 1'b0;
        endcase

        sel_byte = mem_rdata[{offset_q, 3'b000} +: 8];
        sel_half = mem_rdata[{offset_q[1], 4'b0000} +: 16];

        case (size_q)
            SZ_BYTE: load_word = {24'd0, sel_byte};
            SZ_HALF: load_word = {{16{sel_half[0]}}, sel_half};
            default: load_word = mem_rdata;
        endcase

        merged_word = mem_rdata;
        if (size_q == SZ_BYTE)
            merged_word[{offset_q, 3'b000} +: 8] = wdata_q[56:63];
        else
            merged_word[{offset_q[1], 4'b0000} +: 16] = wdata_q[48:63];
    end

    // Reset must suppress a write already in flight on the very edge it is sampled.
    assign mem_we = we_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        offset_q  <= req_offset;
                        wdata_q   <= req_wdata;
                        mem_addr  <= req_addr[0:ADDR_BITS-3];
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state <= RD1;
                        end else if (req_size == SZ_WORD || req_size == SZ_DWORD) begin
                            state     <= WR1;
                            we_q      <= 1'b1;
                            mem_wdata <= (req_size == SZ_DWORD) ? req_wdata[0:31] : req_wdata[32:63];
                        end else begin
                            state <= RMW;
                        end
                    end
                end
                RD1: begin
                    if (size_q == SZ_DWORD) begin
                        first_word <= mem_rdata;
                        // Doublewords are 8-byte aligned, so the second word only sets the LSB.
                        mem_addr[ADDR_BITS-3] <= 1'b1;
                        state <= RD2;
                    end else begin
                        resp_rdata <= {32'd0, load_word};
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RD2: begin
                    resp_rdata <= {first_word, mem_rdata};
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW: begin
                    mem_wdata <= merged_word;
                    we_q      <= 1'b1;
                    state     <= WR1;
                end
                WR1: begin
                    if (size_q == SZ_DWORD) begin
                        mem_addr[ADDR_BITS-3] <= 1'b1;
                        mem_wdata <= wdata_q[32:63];
                        state     <= WR2;
                    end else begin
                        we_q       <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR2: begin
                    we_q       <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    we_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 1024-word RAM plus a byte-array reference model of
// big-endian memory, driven by directed cases and random requests.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [18:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram  [0:1023];
    logic [7:0]  refb [0:4095];
    int          we_count = 0;
    int          total = 0;
    int          bad = 0;

    mem_access_unit #(.ADDR_BITS(19)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = ram[mem_addr[9:0]];

    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_addr[9:0]] <= mem_wdata;
            we_count = we_count + 1;
        end
    end

    // Reference: memory is a flat byte array, most significant byte at the lowest address.
    task automatic model(input logic w, input logic [1:0] sz, input int a, input logic [63:0] d,
                         output logic err, output logic [63:0] rd);
        int nb;
        logic [63:0] v;
        nb  = 1 << sz;
        v   = '0;
        err = (a % nb) != 0;
        rd  = '0;
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                if (w) refb[a+i] = 8'(d >> (8 * (nb - 1 - i)));
                else   v = (v << 8) | 64'(refb[a+i]);
            end
            if (!w) begin
                if (sz == 2'd1) rd = {32'd0, {16{v[15]}}, v[15:0]};
                else            rd = v;
            end
        end
    endtask

    task automatic check_ram(input string name);
        int nbad;
        int first;
        logic [31:0] exp;
        nbad  = 0;
        first = -1;
        for (int w = 0; w < 1024; w++) begin
            exp = {refb[4*w], refb[4*w+1], refb[4*w+2], refb[4*w+3]};
            if (ram[w] !== exp) begin
                nbad++;
                if (first < 0) first = w;
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            exp = {refb[4*first], refb[4*first+1], refb[4*first+2], refb[4*first+3]};
            $display("[TB] FAIL %s ram word %0d: got %h expected %h (%0d bad words)",
                     name, first, ram[first], exp, nbad);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input int a, input logic [63:0] d,
                          input string name);
        logic        exp_err;
        logic [63:0] exp_rd;
        int          exp_lat;
        int          exp_we;
        int          n;
        int          we0;
        int          guard;
        model(w, sz, a, d, exp_err, exp_rd);
        exp_lat = exp_err ? 1 : ((!w && sz != 2'd3) || (w && sz == 2'd2)) ? 2 : 3;
        exp_we  = (exp_err || !w) ? 0 : (sz == 2'd3) ? 2 : 1;

        guard = 0;
        @(negedge clock);
        while (!req_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = 19'(a);
        req_wdata = d;
        we0 = we_count;
        n = 0;
        forever begin
            @(posedge clock);
            n++;
            #1;
            if (resp_valid || n >= 8) break;
            // Scribble over the inputs: the unit must have latched the request already.
            req_write = 1'($urandom);
            req_size  = 2'($urandom_range(0, 3));
            req_addr  = 19'($urandom);
            req_wdata = {$urandom, $urandom};
        end

        total++;
        if (!resp_valid) begin
            bad++;
            $display("[TB] FAIL %s timeout: resp_valid=%b after %0d cycles, required 1", name, resp_valid, n);
        end
        total++;
        if (n !== exp_lat) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
        end
        total++;
        if (resp_err !== exp_err) begin
            bad++;
            $display("[TB] FAIL %s resp_err: got %b expected %b", name, resp_err, exp_err);
        end
        if (!w || exp_err) begin
            total++;
            if (resp_rdata !== exp_rd) begin
                bad++;
                $display("[TB] FAIL %s resp_rdata: got %h expected %h", name, resp_rdata, exp_rd);
            end
        end
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s req_ready during response: got %b expected 0", name, req_ready);
        end
        total++;
        if (we_count - we0 !== exp_we) begin
            bad++;
            $display("[TB] FAIL %s write pulses: got %0d expected %0d", name, we_count - we0, exp_we);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000 || resp_rdata !== 64'd0 || mem_addr !== 17'd0) begin
            bad++;
            $display("[TB] FAIL reset state: ready=%b valid=%b err=%b we=%b rdata=%h addr=%h expected 1 0 0 0 0 0",
                     req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_addr);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_word();
        do_req(1'b1, 2'd2, 'h10, 64'h0000_0000_1234_5678, "word store");
        total++;
        if (ram[4] !== 32'h1234_5678) begin
            bad++;
            $display("[TB] FAIL word store ram[4]: got %h expected 12345678", ram[4]);
        end
        do_req(1'b0, 2'd2, 'h10, 64'd0, "word load");
    endtask

    task automatic test_rmw();
        do_req(1'b1, 2'd0, 'h12, 64'h0000_0000_0000_00AB, "byte store");
        total++;
        if (ram[4] !== 32'h1234_AB78) begin
            bad++;
            $display("[TB] FAIL byte rmw ram[4]: got %h expected 1234ab78", ram[4]);
        end
        do_req(1'b1, 2'd1, 'h12, 64'h0000_0000_0000_C3D4, "half store");
        check_ram("rmw");
    endtask

    task automatic test_subword();
        do_req(1'b1, 2'd2, 'h14, 64'h0000_0000_80FF_7F01, "word5 store");
        do_req(1'b0, 2'd1, 'h14, 64'd0, "half load neg");
        total++;
        if (resp_rdata !== 64'h0000_0000_FFFF_80FF) begin
            bad++;
            $display("[TB] FAIL half sign-extend: got %h expected 00000000ffff80ff", resp_rdata);
        end
        do_req(1'b0, 2'd1, 'h16, 64'd0, "half load pos");
        do_req(1'b0, 2'd0, 'h17, 64'd0, "byte load off3");
        total++;
        if (resp_rdata !== 64'h0000_0000_0000_0001) begin
            bad++;
            $display("[TB] FAIL byte load: got %h expected 0000000000000001", resp_rdata);
        end
        do_req(1'b0, 2'd0, 'h15, 64'd0, "byte load off1");
    endtask

    task automatic test_dword();
        do_req(1'b1, 2'd3, 'h20, 64'hDEAD_BEEF_CAFE_F00D, "dword store");
        total++;
        if (ram[8] !== 32'hDEAD_BEEF || ram[9] !== 32'hCAFE_F00D) begin
            bad++;
            $display("[TB] FAIL dword words 8/9: got %h %h expected deadbeef cafef00d", ram[8], ram[9]);
        end
        do_req(1'b0, 2'd3, 'h20, 64'd0, "dword load");
    endtask

    task automatic test_misaligned();
        do_req(1'b0, 2'd2, 'h11, 64'd0, "misaligned word load");
        do_req(1'b1, 2'd1, 'h13, 64'h0000_0000_0000_FFFF, "misaligned half store");
        do_req(1'b0, 2'd3, 'h24, 64'd0, "misaligned dword load");
        do_req(1'b1, 2'd3, 'h2C, 64'h1111_2222_3333_4444, "misaligned dword store");
        check_ram("misaligned");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), $urandom_range(256, 4088),
                   {$urandom, $urandom}, "random");
        end
        check_ram("random");
    endtask

    task automatic test_reset_midop();
        int we0;
        int seen;
        @(negedge clock);
        while (!req_ready) @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 19'h30;
        req_wdata = 64'h0000_0000_5555_AAAA;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        we0 = we_count;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || mem_addr !== 17'd0) begin
            bad++;
            $display("[TB] FAIL reset abort state: ready=%b valid=%b rdata=%h addr=%h expected 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, mem_addr);
        end
        total++;
        if (ram[12] !== 32'd0 || we_count !== we0) begin
            bad++;
            $display("[TB] FAIL reset abort write: ram[12]=%h pulses=%0d expected 0 0", ram[12], we_count - we0);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (resp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("[TB] FAIL reset abort response: got %0d resp_valid cycles expected 0", seen);
        end
        do_req(1'b0, 2'd2, 'h30, 64'd0, "load after abort");
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) ram[w] = '0;
        for (int b = 0; b < 4096; b++) refb[b] = '0;
        test_reset();
        test_word();
        test_rmw();
        test_subword();
        test_dword();
        test_misaligned();
        test_random();
        test_reset_midop();
        check_ram("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the CPU core and the word-wide RAM (17-bit word address, 32-bit data, combinational read, write on rising clock edge when write enable is high).
- Converts CPU byte-addressed requests into RAM word accesses. Supported sizes: byte, halfword, word and doubleword.
- Sub-word stores become read-modify-write sequences. Doubleword accesses become two word accesses.
- Misaligned requests are rejected with an error response instead of reaching memory.

Parameters:
- ADDR_BITS, 19, byte-address width; word address = upper ADDR_BITS-2 bits (17 for the 1024-word RAM bench).

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 halfword, 2 word, 3 doubleword
- req_addr  input  ADDR_BITS  byte address, bit 0 MSB, big-endian
- req_wdata  input  64  store data, right-justified; [32:63] = word/half/byte data, [0:31] = first word of a doubleword
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  alignment error, valid with resp_valid
- resp_rdata  output  64  load data; valid with resp_valid
- mem_addr  output  17  RAM word address
- mem_we  output  1  RAM write enable
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data, combinational from mem_addr

Behaviour:
- Reset (synchronous, active-high), applied at the next rising edge:
  - State goes to IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0.
- mem_we is combinationally forced to 0 while reset=1, so no RAM write occurs on the edge where reset is sampled, even mid-write.
- States: IDLE, RD1, RD2, RMW, WR1, WR2, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid is high at a rising edge. Address, size, write flag and data are latched.
- Alignment check, at acceptance:
  - halfword needs addr[ADDR_BITS-1]=0.
  - word needs the low 2 bits = 0.
  - doubleword needs the low 3 bits = 0.
  - Violation: go to RESP with resp_err=1. No memory cycle is issued and resp_rdata=0.
- State sequences:
  - load byte/half/word: RD1 -> RESP
  - load doubleword: RD1 -> RD2 -> RESP
  - store word: WR1 -> RESP
  - store doubleword: WR1 -> WR2 -> RESP
  - store byte/half: RMW -> WR1 -> RESP
- Each state lasts exactly one cycle, so latency from the acceptance edge to resp_valid high is:
  - 2 cycles for a single-word load or word store.
  - 3 cycles for a doubleword or sub-word store.
  - 1 cycle for an error.
- Addressing:
  - RD1/WR1/RMW drive mem_addr = word index of req_addr.
  - RD2/WR2 drive that index +1. The doubleword is aligned, so no carry out of the doubleword pair.
  - mem_addr is held stable for the whole state.
- Write data:
  - mem_we=1 only in WR1/WR2.
  - Doubleword: WR1 writes req_wdata[0:31], WR2 writes req_wdata[32:63].
- Read capture:
  - RD1/RMW capture mem_rdata at the end of the state. RD2 captures the second word.
- Lane placement, big-endian:
  - byte offset 0 = bits [0:7], offset 3 = bits [24:31].
  - halfword offset 0 = [0:15], offset 2 = [16:31].
- RMW merge: the captured word keeps all other lanes; the selected lane is replaced by req_wdata's low byte/halfword. The merged word is written in WR1.
- Load formatting into resp_rdata[32:63]:
  - byte: zero-extended.
  - halfword: sign-extended from bit 0 of the halfword.
  - word: as read.
  - doubleword: first word in [0:31], second in [32:63].
  - [0:31]=0 for non-doubleword loads.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in RESP, so back-to-back requests are accepted no earlier than the cycle after the response.
  - resp_rdata/resp_err hold their values until the next response.
- req_valid is ignored outside IDLE, and latched request fields are not affected by input changes after acceptance.
- Reset in any state aborts the operation: no resp_valid is produced for it, and the unit is in IDLE on the cycle after reset deasserts.

Test Plan:
- Word store then load: store addr 0x00010, data 0x12345678 -> RAM word 4 = 0x12345678 after 2 cycles; load same -> resp_rdata[32:63]=0x12345678 two cycles after accept, resp_err=0.
- Byte store RMW: RAM word 4 = 0x12345678, store byte 0xAB at addr 0x00012 -> word 4 = 0x1234AB78, exactly one mem_we pulse, resp_valid 3 cycles after accept.
- Sub-word loads: word 5 = 0x80FF7F01; load half at 0x00014 -> 0xFFFF80FF; load byte at 0x00017 -> 0x00000001.
- Doubleword: store 0xDEADBEEF_CAFEF00D at 0x00020 -> words 8/9 = 0xDEADBEEF/0xCAFEF00D; load back -> resp_rdata identical.
- Misalignment: load word at 0x00011, store half at 0x00013, load doubleword at 0x00024 -> each resp_err=1 one cycle after accept, mem_we never high, RAM unchanged.
- Reset mid-op: assert reset during the WR1 cycle of a word store to 0x00030 (prior value 0x0) -> word 12 stays 0, no resp_valid, req_ready=1 the cycle after reset drops, resp_valid/resp_rdata/mem_addr read 0.
